// File: rtl/multiplier_eval_sequencer.sv
// Exhaustive evaluation controller for one candidate multiplier.
// Sweeps every (A,B) pair, checks each product against A*B and accumulates error statistics.
module multiplier_eval_sequencer #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     cand_a,
    output logic [WIDTH-1:0]     cand_b,
    input  logic [2*WIDTH-1:0]   cand_p,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [2*WIDTH-1:0]   bit_err_mask
);

    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned DCW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [PW:0]      err_q, err_d;
    logic             fv_q, fv_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [PW-1:0]    mask_q, mask_d;

    logic [WIDTH-1:0] pres_a, pres_b;
    logic [PW-1:0]    pres_gold;
    logic             pres_vld;

    logic             cmp_vld;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic [PW-1:0]    cmp_gold;
    logic             mismatch;

    assign pres_a    = idx_q[PW-1:WIDTH];
    assign pres_b    = idx_q[WIDTH-1:0];
    assign pres_vld  = (state_q == S_RUN);
    assign pres_gold = PW'(pres_a) * PW'(pres_b);

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    // Golden vector travels alongside the candidate pipeline so the compare lines up with cand_p.
    generate
        if (LAT == 0) begin : g_comb
            assign cmp_vld  = pres_vld;
            assign cmp_a    = pres_a;
            assign cmp_b    = pres_b;
            assign cmp_gold = pres_gold;
        end else begin : g_pipe
            logic [LAT-1:0]   vld_q;
            logic [WIDTH-1:0] a_q [LAT];
            logic [WIDTH-1:0] b_q [LAT];
            logic [PW-1:0]    g_q [LAT];

            always_ff @(posedge clk) begin
                if (!rst_n || !busy) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= pres_vld;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                a_q[0] <= pres_a;
                b_q[0] <= pres_b;
                g_q[0] <= pres_gold;
                for (int unsigned i = 1; i < LAT; i++) begin
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                    g_q[i] <= g_q[i-1];
                end
            end

            assign cmp_vld  = vld_q[LAT-1];
            assign cmp_a    = a_q[LAT-1];
            assign cmp_b    = b_q[LAT-1];
            assign cmp_gold = g_q[LAT-1];
        end
    endgenerate

    assign mismatch = busy && cmp_vld && (cand_p != cmp_gold);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        mask_d  = mask_q;

        unique case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start && !abort) begin
                    state_d = S_RUN;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    mask_d  = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q == '1) begin
                    if (LAT > 0) begin
                        state_d = S_DRAIN;
                        drain_d = DCW'(LAT - 1);
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (mismatch) begin
            err_d  = err_q + 1'b1;
            mask_d = mask_q | (cand_p ^ cmp_gold);
            if (!fv_q) begin
                fv_d = 1'b1;
                fa_d = cmp_a;
                fb_d = cmp_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            mask_q  <= mask_d;
        end
    end

    assign cand_a       = idx_q[PW-1:WIDTH];
    assign cand_b       = idx_q[WIDTH-1:0];
    assign err_count    = err_q;
    assign fail_valid   = fv_q;
    assign fail_a       = fa_q;
    assign fail_b       = fb_q;
    assign bit_err_mask = mask_q;

endmodule

// File: tb/tb_multiplier_eval_sequencer.sv
// Bench for multiplier_eval_sequencer: three instances (LAT 0, 2, and LAT 1 against a 2-stage candidate)
// checked against a sweep model of the expected error statistics.
module tb_multiplier_eval_sequencer;

    localparam int unsigned NV = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_w [3];
    logic       abort_w [3];
    logic [1:0] ca      [3];
    logic [1:0] cb      [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [4:0] err_w   [3];
    logic       fv_w    [3];
    logic [1:0] fa_w    [3];
    logic [1:0] fb_w    [3];
    logic [3:0] mask_w  [3];
    logic [3:0] cp0, cp1, cp2;

    int unsigned cand_mode [3];
    logic [63:0] fault_vec;
    int unsigned dut_lat  [3] = '{0, 2, 1};
    int unsigned cand_lat [3] = '{0, 2, 2};

    int n_cmp = 0;
    int n_bad = 0;

    // mode 0: exact, 1: stuck-at-0, 2: P[3] stuck-at-1, 3: random per-vector fault table
    function automatic logic [3:0] cand_f(input int unsigned m, input logic [1:0] a, input logic [1:0] b,
                                          input logic [63:0] fv);
        logic [3:0] p;
        p = {2'b00, a} * {2'b00, b};
        case (m)
            0: return p;
            1: return 4'h0;
            2: return p | 4'h8;
            default: return p ^ fv[int'({a, b}) * 4 +: 4];
        endcase
    endfunction

    assign cp0 = cand_f(cand_mode[0], ca[0], cb[0], fault_vec);

    logic [3:0] s1a = '0, s1b = '0, s2a = '0, s2b = '0;
    always @(posedge clk) begin
        s1a <= cand_f(cand_mode[1], ca[1], cb[1], fault_vec);
        s1b <= s1a;
        s2a <= cand_f(cand_mode[2], ca[2], cb[2], fault_vec);
        s2b <= s2a;
    end
    assign cp1 = s1b;
    assign cp2 = s2b;

    multiplier_eval_sequencer #(.WIDTH(2), .LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .abort(abort_w[0]),
        .cand_a(ca[0]), .cand_b(cb[0]), .cand_p(cp0), .busy(busy_w[0]), .done(done_w[0]),
        .err_count(err_w[0]), .fail_valid(fv_w[0]), .fail_a(fa_w[0]), .fail_b(fb_w[0]),
        .bit_err_mask(mask_w[0]));

    multiplier_eval_sequencer #(.WIDTH(2), .LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .abort(abort_w[1]),
        .cand_a(ca[1]), .cand_b(cb[1]), .cand_p(cp1), .busy(busy_w[1]), .done(done_w[1]),
        .err_count(err_w[1]), .fail_valid(fv_w[1]), .fail_a(fa_w[1]), .fail_b(fb_w[1]),
        .bit_err_mask(mask_w[1]));

    multiplier_eval_sequencer #(.WIDTH(2), .LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .abort(abort_w[2]),
        .cand_a(ca[2]), .cand_b(cb[2]), .cand_p(cp2), .busy(busy_w[2]), .done(done_w[2]),
        .err_count(err_w[2]), .fail_valid(fv_w[2]), .fail_a(fa_w[2]), .fail_b(fb_w[2]),
        .bit_err_mask(mask_w[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sweep of all vectors; skew = how many vectors the candidate output lags the checker's alignment.
    task automatic model(input int unsigned m, input int skew, output int unsigned e, output int unsigned fv,
                         output int unsigned fa, output int unsigned fb, output int unsigned mask);
        logic [3:0] gold, seen;
        int s;
        e = 0; fv = 0; fa = 0; fb = 0; mask = 0;
        for (int k = 0; k < int'(NV); k++) begin
            gold = 4'((k / 4) * (k % 4));
            s    = k - skew;
            seen = (s < 0) ? cand_f(m, 2'd0, 2'd0, fault_vec) : cand_f(m, 2'(s / 4), 2'(s % 4), fault_vec);
            if (seen != gold) begin
                e++;
                mask = mask | int'(seen ^ gold);
                if (fv == 0) begin
                    fv = 1;
                    fa = k / 4;
                    fb = k % 4;
                end
            end
        end
    endtask

    task automatic randomize_faults();
        fault_vec = '0;
        for (int i = 0; i < int'(NV); i++) begin
            if ($urandom_range(0, 3) == 0) fault_vec[i*4 +: 4] = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic run_eval(input int u, input int unsigned m, input bit poke);
        int unsigned cyc;
        bit seq_ok;
        int unsigned e, fv, fa, fb, mask;
        cand_mode[u] = m;
        @(negedge clk); start_w[u] = 1'b1;
        @(negedge clk); start_w[u] = 1'b0;
        cyc = 1;
        seq_ok = 1'b1;
        while (!done_w[u] && cyc < 200) begin
            if (cyc <= NV && (int'({ca[u], cb[u]}) != int'(cyc - 1) || !busy_w[u])) seq_ok = 1'b0;
            start_w[u] = (poke && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start_w[u] = 1'b0;
        chk($sformatf("latency_u%0d_m%0d", u, m), cyc, NV + dut_lat[u] + 1);
        chk($sformatf("sequence_u%0d_m%0d", u, m), seq_ok, 1);
        @(negedge clk);
        chk($sformatf("done_pulse_u%0d", u), done_w[u], 0);
        chk($sformatf("busy_after_u%0d", u), busy_w[u], 0);
        model(m, int'(cand_lat[u]) - int'(dut_lat[u]), e, fv, fa, fb, mask);
        chk($sformatf("err_count_u%0d_m%0d", u, m), err_w[u], e);
        chk($sformatf("fail_valid_u%0d_m%0d", u, m), fv_w[u], fv);
        chk($sformatf("fail_a_u%0d_m%0d", u, m), fa_w[u], fa);
        chk($sformatf("fail_b_u%0d_m%0d", u, m), fb_w[u], fb);
        chk($sformatf("mask_u%0d_m%0d", u, m), mask_w[u], mask);
    endtask

    task automatic wait_idx(input int u, input int unsigned target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (busy_w[u] && int'({ca[u], cb[u]}) == int'(target)) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        bit found;
        int unsigned dn;
        rst_n = 1'b0;
        fault_vec = '0;
        for (int u = 0; u < 3; u++) begin
            start_w[u] = 1'b0;
            abort_w[u] = 1'b0;
            cand_mode[u] = 0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_err_u%0d", u), err_w[u], 0);
            chk($sformatf("rst_fv_u%0d", u), fv_w[u], 0);
            chk($sformatf("rst_mask_u%0d", u), mask_w[u], 0);
            chk($sformatf("rst_busy_done_u%0d", u), {busy_w[u], done_w[u]}, 0);
            chk($sformatf("rst_cand_u%0d", u), {ca[u], cb[u], fa_w[u], fb_w[u]}, 0);
        end
        rst_n = 1'b1;

        run_eval(0, 0, 1'b1);
        run_eval(0, 1, 1'b0);
        run_eval(0, 2, 1'b0);
        run_eval(1, 0, 1'b1);
        run_eval(2, 0, 1'b0);
        chk("lat_mismatch_nonzero", (err_w[2] != 0), 1);

        for (int r = 0; r < 4; r++) begin
            randomize_faults();
            run_eval(0, 3, 1'b0);
            run_eval(1, 3, 1'b0);
        end

        // Abort mid-run, confirm no done, then a clean rerun.
        cand_mode[0] = 1;
        @(negedge clk); start_w[0] = 1'b1;
        @(negedge clk); start_w[0] = 1'b0;
        wait_idx(0, 7, found);
        chk("abort_wait_idx7", found, 1);
        abort_w[0] = 1'b1;
        @(negedge clk); abort_w[0] = 1'b0;
        chk("abort_busy", busy_w[0], 0);
        chk("abort_partial_fv", fv_w[0], 1);
        dn = 0;
        repeat (25) begin
            if (done_w[0]) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", dn, 0);
        run_eval(0, 1, 1'b0);

        // start and abort together in IDLE: abort wins.
        @(negedge clk); start_w[0] = 1'b1; abort_w[0] = 1'b1;
        @(negedge clk); start_w[0] = 1'b0; abort_w[0] = 1'b0;
        chk("idle_abort_wins", busy_w[0], 0);

        // Reset in the middle of a run.
        cand_mode[0] = 1;
        @(negedge clk); start_w[0] = 1'b1;
        @(negedge clk); start_w[0] = 1'b0;
        wait_idx(0, 10, found);
        chk("rst_wait_idx10", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_err", err_w[0], 0);
        chk("midrst_fv_mask", {fv_w[0], mask_w[0]}, 0);
        chk("midrst_busy_done", {busy_w[0], done_w[0]}, 0);
        chk("midrst_cand_fail", {ca[0], cb[0], fa_w[0], fb_w[0]}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_stays_idle", busy_w[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multiplier_eval_sequencer.md
Name: multiplier_eval_sequencer

Overview:
Exhaustive-evaluation controller for one candidate multiplier produced by the design-space exploration flow.
- On start, drives every operand pair (A,B) into the candidate, compares each product against an internal golden A*B, and accumulates an error count, a first-failing vector and a per-bit error mask.
- Results form the functional-correctness term of the RL reward.
- Sits between the environment testbench/harness and the candidate multiplier instance.

Parameters:
- WIDTH, 2: operand width in bits; product is 2*WIDTH bits; vector space is 2^(2*WIDTH).
- LAT, 0: candidate latency in cycles (0 = combinational; >0 = pipelined candidate with LAT register stages).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin an evaluation; sampled only in IDLE.
- abort  in  1  cancel an evaluation in progress; return to IDLE without done.
- cand_a  out  WIDTH  operand A to candidate (registered).
- cand_b  out  WIDTH  operand B to candidate (registered).
- cand_p  in  2*WIDTH  candidate product.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- err_count  out  2*WIDTH+1  number of mismatching vectors.
- fail_valid  out  1  at least one mismatch recorded.
- fail_a  out  WIDTH  A of first mismatching vector.
- fail_b  out  WIDTH  B of first mismatching vector.
- bit_err_mask  out  2*WIDTH  OR over all vectors of (cand_p XOR golden).

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE.
  - cand_a, cand_b, busy, done, err_count, fail_valid, fail_a, fail_b and bit_err_mask all = 0.
  - Reset mid-RUN/DRAIN discards all progress.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN.
  - Clears err_count, fail_*, bit_err_mask and the vector index idx (2*WIDTH bits).
  - Previous results hold in IDLE until the next accepted start.
- RUN:
  - Each cycle presents idx: cand_a = idx[2W-1:W], cand_b = idx[W-1:0]; idx increments by 1.
  - Exactly 2^(2W) cycles (idx 0 .. max).
  - At the last idx -> DRAIN if LAT>0, else DONE. Index does not wrap into a second pass.
- Golden product: the unsigned product of presented A and B, full 2*WIDTH bits, no truncation.
  - Held in a LAT-deep delay line alongside A and B, so the compare uses cand_p LAT cycles after presentation.
  - LAT=0: compare in the same cycle as presentation.
- Compare, when a delayed vector is valid:
  - mismatch -> err_count+1, and bit_err_mask |= (cand_p ^ golden).
  - If fail_valid=0, latch fail_a/fail_b and set fail_valid. Later mismatches never overwrite them.
- DRAIN: LAT cycles to flush outstanding compares; cand_a/cand_b hold the last vector; -> DONE.
- DONE: done=1 for exactly one cycle, busy=0; -> IDLE.
- busy = 1 in RUN and DRAIN only.
- start while busy is ignored.
- abort (RUN or DRAIN):
  - -> IDLE next edge, no done pulse; partial results remain visible but are invalid.
  - abort has priority over the last-vector transition.
- start and abort both high in IDLE: abort wins, start is ignored.
- err_count width holds the full count 2^(2W) without overflow.
- Total start-accepted-to-done cycles: 2^(2W) + LAT + 1.

Test Plan:
- WIDTH=2, LAT=0, correct candidate (P=A*B), start pulse at cycle 0 -> RUN cycles 1-16 with idx 0..15; done at cycle 17; err_count=0, fail_valid=0, mask=0x0.
- WIDTH=2, LAT=0, candidate P stuck at 0 -> err_count=9, fail_valid=1, fail_a=1, fail_b=1, bit_err_mask=0xF.
- WIDTH=2, LAT=0, candidate with P[3] stuck-at-1 -> err_count=15 (only 3*3=9 passes), fail_a=0, fail_b=0, bit_err_mask=0x8.
- WIDTH=2, LAT=2, correct candidate through 2 register stages -> done exactly 19 cycles after start accepted, err_count=0. The same bench with LAT set to 1 against the 2-stage candidate yields a nonzero err_count.
- Abort at idx=7, then start again with the stuck-at-0 candidate -> no done after the abort; second run reports err_count=9 (no carry-over).
- rst_n=0 during RUN at idx=10 -> next cycle all outputs 0, state IDLE. Start asserted while busy mid-run -> ignored; done still at cycle 17.
